serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares one external single-bit full_adder cell to process WIDTH-bit operands, one bit per clock, LSB first. It holds the operand and result shift registers, the carry flip-flop and the start/busy/done handshake. It drives the full_adder inputs and samples its outputs. It sits between the operand source and any consumer of the Result/Done pair.

---
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller driving one external full_adder cell.
// Ports: Clock/Reset, Start/Sub/A_in/B_in request, FA_* adder link,
//        Busy/Done handshake, Result/Carry_out/Overflow held results.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_Carry_in,
  input  logic             FA_Sum,
  input  logic             FA_Carry_out,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Carry_out,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        // The edge that closes DONE may accept the next request,
        // giving one operation every WIDTH+1 cycles.
        if (Start) begin
          a_sh_d  = A_in;
          b_sh_d  = Sub ? ~B_in : B_in;
          carry_d = Sub;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_sh_d  = {FA_Sum, r_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = FA_Carry_out;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          result_d = {FA_Sum, r_sh_q[WIDTH-1:1]};
          cout_d   = FA_Carry_out;
          // carry into the MSB differs from carry out of it
          ovf_d    = carry_q ^ FA_Carry_out;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign FA_A        = run & a_sh_q[0];
  assign FA_B        = run & b_sh_q[0];
  assign FA_Carry_in = run & carry_q;
  assign Busy        = run;
  assign Done        = (state_q == DONE);
  assign Result      = result_q;
  assign Carry_out   = cout_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic/timing model plus directed ops.
// Ports: drives all DUT inputs, models the full_adder combinationally.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         FA_A, FA_B, FA_Carry_in;
  logic         FA_Sum, FA_Carry_out;
  logic         Busy, Done, Carry_out, Overflow;
  logic [W-1:0] Result;

  int n_chk = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub),
    .A_in(A_in), .B_in(B_in),
    .FA_A(FA_A), .FA_B(FA_B), .FA_Carry_in(FA_Carry_in),
    .FA_Sum(FA_Sum), .FA_Carry_out(FA_Carry_out),
    .Busy(Busy), .Done(Done), .Result(Result),
    .Carry_out(Carry_out), .Overflow(Overflow)
  );

  assign FA_Sum = FA_A ^ FA_B ^ FA_Carry_in;
  assign FA_Carry_out = (FA_A & FA_B) | (FA_Carry_in & (FA_A ^ FA_B));

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1..W busy cycles, W+1 done cycle.
  int           ph;
  logic [W-1:0] ma, mbp;
  logic         ms;
  logic [W-1:0] e_res;
  logic         e_c, e_v;

  function automatic logic [W:0] add_full(input logic [W-1:0] a,
                                          input logic [W-1:0] bp,
                                          input logic cin);
    return {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic cin_at(input logic [W-1:0] a,
                                  input logic [W-1:0] bp,
                                  input logic cin, input int i);
    logic [W:0] mask, s;
    mask = ({{W{1'b0}}, 1'b1} << i) - 1;
    s = ({1'b0, a} & mask) + ({1'b0, bp} & mask) + {{W{1'b0}}, cin};
    return s[i];
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ph    <= 0;
      ma    <= '0;
      mbp   <= '0;
      ms    <= 1'b0;
      e_res <= '0;
      e_c   <= 1'b0;
      e_v   <= 1'b0;
    end else if (ph == 0 || ph == W + 1) begin
      if (Start) begin
        ph  <= 1;
        ma  <= A_in;
        mbp <= Sub ? ~B_in : B_in;
        ms  <= Sub;
      end else begin
        ph <= 0;
      end
    end else if (ph == W) begin
      logic [W:0] s;
      s = add_full(ma, mbp, ms);
      ph    <= W + 1;
      e_res <= s[W-1:0];
      e_c   <= s[W];
      e_v   <= (ma[W-1] == mbp[W-1]) && (s[W-1] != ma[W-1]);
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      logic bsy;
      bsy = (ph >= 1 && ph <= W);
      chk("busy", Busy, bsy);
      chk("done", Done, ph == W + 1);
      chk("result", Result, e_res);
      chk("carry_out", Carry_out, e_c);
      chk("overflow", Overflow, e_v);
      if (bsy) begin
        chk("fa_a", FA_A, ma[ph-1]);
        chk("fa_b", FA_B, mbp[ph-1]);
        chk("fa_cin", FA_Carry_in, cin_at(ma, mbp, ms, ph - 1));
      end else begin
        chk("fa_idle", {FA_A, FA_B, FA_Carry_in}, 3'b000);
      end
    end
  end

  task automatic run_op(input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er,
                        input logic ec, input logic ev);
    int cyc, nb;
    bit got;
    @(posedge Clock); #2;
    Start = 1'b1; Sub = s; A_in = a; B_in = b;
    @(posedge Clock); #2;
    Start = 1'b0; Sub = ~s; A_in = ~a; B_in = 8'h5A;
    cyc = 0; nb = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge Clock);
      cyc++;
      if (Done) got = 1;
      else if (Busy) nb++;
    end
    chk("done_latency", cyc, 9);
    chk("busy_cycles", nb, W);
    chk("lit_result", Result, er);
    chk("lit_carry", Carry_out, ec);
    chk("lit_ovf", Overflow, ev);
  endtask

  initial begin
    int cyc, t1, nd;
    bit got;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_out", {Busy, Done, Result, Carry_out, Overflow}, '0);
    chk("rst_fa", {FA_A, FA_B, FA_Carry_in}, 3'b000);
    @(posedge Clock); #2;
    Reset = 1'b0;

    run_op(1'b0, 8'h3C, 8'h2A, 8'h66, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start pulses during RUN and inside the DONE cycle are ignored.
    @(posedge Clock); #2;
    Start = 1'b1; Sub = 1'b0; A_in = 8'h11; B_in = 8'h22;
    @(posedge Clock); #2;
    Start = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Start = 1'b1; A_in = 8'hF0; B_in = 8'h0F;
    @(posedge Clock); #2;
    Start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge Clock);
      cyc++;
      if (Done) got = 1;
    end
    chk("ign_done_seen", got, 1'b1);
    #1 Start = 1'b1;
    #2 Start = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("ign_idle", {Busy, Done}, 2'b00);
    end
    chk("ign_result", Result, 8'h33);

    // Asynchronous reset in RUN cycle 4.
    @(posedge Clock); #2;
    Start = 1'b1; A_in = 8'h55; B_in = 8'h22;
    @(posedge Clock); #2;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst_out", {Busy, Done, Result, Carry_out, Overflow}, '0);
    chk("arst_fa", {FA_A, FA_B, FA_Carry_in}, 3'b000);
    @(posedge Clock); #2;
    Reset = 1'b0;
    run_op(1'b0, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0);

    // Back-to-back with Start held high.
    @(posedge Clock); #2;
    Start = 1'b1; Sub = 1'b0; A_in = 8'h01; B_in = 8'h01;
    @(posedge Clock); #2;
    A_in = 8'h02; B_in = 8'h02;
    cyc = 0; nd = 0; t1 = 0;
    while (nd < 2 && cyc < 40) begin
      @(negedge Clock);
      cyc++;
      if (Done) begin
        nd++;
        if (nd == 1) begin
          t1 = cyc;
          chk("b2b_res1", Result, 8'h02);
          @(posedge Clock); #2;
          Start = 1'b0;
        end else begin
          chk("b2b_gap", cyc - t1, 9);
          chk("b2b_res2", Result, 8'h04);
        end
      end
    end
    chk("b2b_count", nd, 2);
    repeat (3) @(posedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
